// File: rtl/chacha_aead_seq_if.sv
// Host AAD/payload streams and core-side handshakes of the ChaCha20-Poly1305 message sequencer.
// master is the sequencer; slave is the host/core environment around it.
interface chacha_aead_seq_if;
   logic         h_aad_valid;
   logic [127:0] h_aad_data;
   logic [15:0]  h_aad_keep;
   logic         h_aad_last;
   logic         h_aad_ready;
   logic         h_pld_valid;
   logic [127:0] h_pld_data;
   logic [15:0]  h_pld_keep;
   logic         h_pld_last;
   logic         h_pld_ready;
   logic         cfg_we;
   logic         ks_req;
   logic         ks_valid;
   logic         aad_valid;
   logic [127:0] aad_data;
   logic [15:0]  aad_keep;
   logic         aad_ready;
   logic         aad_done;
   logic         pld_valid;
   logic [127:0] pld_data;
   logic [15:0]  pld_keep;
   logic         pld_ready;
   logic         pld_done;
   logic         len_valid;
   logic [127:0] len_block;
   logic         len_ready;
   logic         lens_done;
   logic [127:0] tag_pre_xor;
   logic         tag_pre_xor_valid;
   logic [127:0] tagmask;
   logic         tagmask_valid;

   modport master (
      input  h_aad_valid, h_aad_data, h_aad_keep, h_aad_last,
      output h_aad_ready,
      input  h_pld_valid, h_pld_data, h_pld_keep, h_pld_last,
      output h_pld_ready,
      output cfg_we, ks_req, aad_valid, aad_data, aad_keep, pld_valid, pld_data, pld_keep,
      output len_valid, len_block,
      input  ks_valid, aad_ready, aad_done, pld_ready, pld_done, len_ready, lens_done,
      input  tag_pre_xor, tag_pre_xor_valid, tagmask, tagmask_valid
   );

   modport slave (
      output h_aad_valid, h_aad_data, h_aad_keep, h_aad_last,
      input  h_aad_ready,
      output h_pld_valid, h_pld_data, h_pld_keep, h_pld_last,
      input  h_pld_ready,
      input  cfg_we, ks_req, aad_valid, aad_data, aad_keep, pld_valid, pld_data, pld_keep,
      input  len_valid, len_block,
      output ks_valid, aad_ready, aad_done, pld_ready, pld_done, len_ready, lens_done,
      output tag_pre_xor, tag_pre_xor_valid, tagmask, tagmask_valid
   );
endinterface

// File: rtl/chacha_aead_seq.sv
// Message sequencer for a ChaCha20-Poly1305 core: config, keystream, AAD, payload,
// length block and tag, with a per-state watchdog and abort.
module chacha_aead_seq #(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 aad_none,
   input  logic                 pld_none,
   input  logic                 abort,
   chacha_aead_seq_if.master    bus,
   output logic [127:0]         tag,
   output logic                 tag_valid,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);
   typedef enum logic [3:0] {
      IDLE, CFG, KS, KS_W, A_GET, A_PUT, A_W, P_GET, P_PUT, P_W, L_PUT, L_W, T_W, FIN
   } state_t;

   typedef struct packed {
      logic busy;
      logic cfg_we;
      logic ks_req;
      logic h_aad_ready;
      logic aad_valid;
      logic h_pld_ready;
      logic pld_valid;
      logic len_valid;
      logic fin;
   } outs_t;

   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

   state_t          st;
   outs_t           outs;
   logic [WD_W-1:0] wdog;
   logic            skip_aad, skip_pld;
   logic [63:0]     aad_bytes, pld_bytes;
   logic [127:0]    beat_data;
   logic [15:0]     beat_keep;
   logic            beat_last;
   logic            have_pre, have_mask;
   logic [127:0]    pre_q, mask_q;
   logic [127:0]    pre_eff, mask_eff;
   logic            pre_ok, mask_ok;
   logic            leaving, timeout_hit;
   state_t          pld_or_len, ks_next, aw_next, pw_next;

   function automatic outs_t decode(state_t s);
      outs_t o;
      o             = '0;
      o.busy        = (s != IDLE);
      o.cfg_we      = (s == CFG);
      o.ks_req      = (s == KS);
      o.h_aad_ready = (s == A_GET);
      o.aad_valid   = (s == A_PUT);
      o.h_pld_ready = (s == P_GET);
      o.pld_valid   = (s == P_PUT);
      o.len_valid   = (s == L_PUT);
      o.fin         = (s == FIN);
      return o;
   endfunction

   function automatic logic [63:0] popcount16(logic [15:0] k);
      logic [63:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) n = n + 64'(k[i]);
      return n;
   endfunction

   function automatic logic is_wait_state(state_t s);
      return s inside {KS_W, A_PUT, A_W, P_PUT, P_W, L_PUT, L_W, T_W};
   endfunction

   // A tag half that arrived early is replayed from its latch when the other half shows up.
   assign pre_ok   = have_pre | bus.tag_pre_xor_valid;
   assign mask_ok  = have_mask | bus.tagmask_valid;
   assign pre_eff  = have_pre ? pre_q : bus.tag_pre_xor;
   assign mask_eff = have_mask ? mask_q : bus.tagmask;

   always_comb begin
      leaving = 1'b0;
      case (st)
         KS_W:    leaving = bus.ks_valid;
         A_PUT:   leaving = bus.aad_ready;
         A_W:     leaving = bus.aad_done;
         P_PUT:   leaving = bus.pld_ready;
         P_W:     leaving = bus.pld_done;
         L_PUT:   leaving = bus.len_ready;
         L_W:     leaving = bus.lens_done;
         T_W:     leaving = pre_ok & mask_ok;
         default: leaving = 1'b0;
      endcase
      pld_or_len  = skip_pld ? L_PUT : P_GET;
      ks_next     = skip_aad ? pld_or_len : A_GET;
      aw_next     = beat_last ? pld_or_len : A_GET;
      pw_next     = beat_last ? L_PUT : P_GET;
      timeout_hit = is_wait_state(st) && !leaving && (wdog == WD_W'(TIMEOUT_CYC - 1));
   end

   // Beat and tag-half holding registers carry data only and need no reset.
   always_ff @(posedge clk) begin
      if (st == A_GET && bus.h_aad_valid) begin
         beat_data <= bus.h_aad_data;
         beat_keep <= bus.h_aad_keep;
         beat_last <= bus.h_aad_last;
      end else if (st == P_GET && bus.h_pld_valid) begin
         beat_data <= bus.h_pld_data;
         beat_keep <= bus.h_pld_keep;
         beat_last <= bus.h_pld_last;
      end
      if (st == T_W) begin
         pre_q  <= pre_eff;
         mask_q <= mask_eff;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= IDLE;
         outs      <= '0;
         wdog      <= '0;
         skip_aad  <= 1'b0;
         skip_pld  <= 1'b0;
         aad_bytes <= '0;
         pld_bytes <= '0;
         have_pre  <= 1'b0;
         have_mask <= 1'b0;
         tag       <= '0;
         err       <= 1'b0;
      end else if (abort) begin
         st        <= IDLE;
         outs      <= '0;
         wdog      <= '0;
         have_pre  <= 1'b0;
         have_mask <= 1'b0;
      end else if (timeout_hit) begin
         st        <= IDLE;
         outs      <= '0;
         wdog      <= '0;
         have_pre  <= 1'b0;
         have_mask <= 1'b0;
         err       <= 1'b1;
      end else begin
         outs      <= decode(st);
         wdog      <= (is_wait_state(st) && !leaving) ? wdog + WD_W'(1) : '0;
         have_pre  <= 1'b0;
         have_mask <= 1'b0;
         case (st)
            IDLE: if (start) begin
               st        <= CFG;
               outs      <= decode(CFG);
               aad_bytes <= '0;
               pld_bytes <= '0;
               err       <= 1'b0;
               skip_aad  <= aad_none;
               skip_pld  <= pld_none;
            end
            CFG: begin st <= KS;   outs <= decode(KS);   end
            KS:  begin st <= KS_W; outs <= decode(KS_W); end
            KS_W:  if (leaving) begin st <= ks_next; outs <= decode(ks_next); end
            A_GET: if (bus.h_aad_valid) begin
               st        <= A_PUT;
               outs      <= decode(A_PUT);
               aad_bytes <= aad_bytes + popcount16(bus.h_aad_keep);
            end
            A_PUT: if (leaving) begin st <= A_W;     outs <= decode(A_W);     end
            A_W:   if (leaving) begin st <= aw_next; outs <= decode(aw_next); end
            P_GET: if (bus.h_pld_valid) begin
               st        <= P_PUT;
               outs      <= decode(P_PUT);
               pld_bytes <= pld_bytes + popcount16(bus.h_pld_keep);
            end
            P_PUT: if (leaving) begin st <= P_W;     outs <= decode(P_W);     end
            P_W:   if (leaving) begin st <= pw_next; outs <= decode(pw_next); end
            L_PUT: if (leaving) begin st <= L_W;     outs <= decode(L_W);     end
            L_W:   if (leaving) begin st <= T_W;     outs <= decode(T_W);     end
            T_W: if (leaving) begin
               st   <= FIN;
               outs <= decode(FIN);
               tag  <= pre_eff ^ mask_eff;
            end else begin
               have_pre  <= pre_ok;
               have_mask <= mask_ok;
            end
            FIN:     begin st <= IDLE; outs <= decode(IDLE); end
            default: begin st <= IDLE; outs <= decode(IDLE); end
         endcase
      end
   end

   assign busy            = outs.busy;
   assign done            = outs.fin;
   assign tag_valid       = outs.fin;
   assign bus.cfg_we      = outs.cfg_we;
   assign bus.ks_req      = outs.ks_req;
   assign bus.h_aad_ready = outs.h_aad_ready;
   assign bus.aad_valid   = outs.aad_valid;
   assign bus.h_pld_ready = outs.h_pld_ready;
   assign bus.pld_valid   = outs.pld_valid;
   assign bus.len_valid   = outs.len_valid;
   assign bus.aad_data    = beat_data;
   assign bus.aad_keep    = beat_keep;
   assign bus.pld_data    = beat_data;
   assign bus.pld_keep    = beat_keep;
   assign bus.len_block   = {aad_bytes, pld_bytes};
endmodule
